// File: rtl/cam_banked_search.sv
// cam_banked_search: content-addressable memory searched one bank per cycle,
// reporting lowest matching index, match count and multi-match.
`default_nettype none

module cam_banked_search #(
  parameter int CAM_Width = 48,
  parameter int CAM_Depth = 48,
  parameter int Banks     = 4
) (
  input  logic                             Clk,
  input  logic                             Rest,
  input  logic                             Writ_Enable,
  input  logic                             Inval_Enable,
  input  logic [$clog2(CAM_Depth)-1:0]     WR_Addr,
  input  logic [CAM_Width-1:0]             Data_IN,
  input  logic                             Cmp_Start,
  input  logic [CAM_Width-1:0]             CMP_Din,
  output logic                             Busy,
  output logic                             Done,
  output logic                             Match,
  output logic                             Multi_Match,
  output logic [$clog2(CAM_Depth)-1:0]     Match_Addr,
  output logic [$clog2(CAM_Depth+1)-1:0]   Match_Count
);

  localparam int AW = $clog2(CAM_Depth);
  localparam int CW = $clog2(CAM_Depth + 1);
  localparam int E  = CAM_Depth / Banks;
  localparam int BW = (Banks > 1) ? $clog2(Banks) : 1;

  if (CAM_Depth < 2 || (CAM_Depth % Banks) != 0) begin : g_bad_params
    $error("cam_banked_search: CAM_Depth must be >= 2 and a multiple of Banks");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, SEARCH = 2'd1, DONE = 2'd2} state_e;

  logic [CAM_Width-1:0] mem_q [CAM_Depth];
  logic [CAM_Depth-1:0] valid_q, valid_d;
  state_e               state_q, state_d;
  logic [BW-1:0]        bank_q, bank_d;
  logic [CAM_Width-1:0] key_q, key_d;
  logic [CW-1:0]        acc_cnt_q, acc_cnt_d;
  logic                 acc_hit_q, acc_hit_d;
  logic [AW-1:0]        acc_addr_q, acc_addr_d;
  logic                 res_match_q, res_match_d;
  logic                 res_multi_q, res_multi_d;
  logic [AW-1:0]        res_addr_q, res_addr_d;
  logic [CW-1:0]        res_cnt_q, res_cnt_d;

  logic                 wr_ok;
  logic [AW-1:0]        bank_base, idx;
  logic [CW-1:0]        bank_pop;
  logic                 bank_any;
  logic [AW-1:0]        bank_first;

  // Out-of-range addresses are dropped; nothing is accepted mid-search.
  assign wr_ok = (state_q != SEARCH) && ({1'b0, WR_Addr} < (AW+1)'(CAM_Depth));

  always_comb begin
    valid_d = valid_q;
    if (wr_ok && Inval_Enable) begin
      valid_d[WR_Addr] = 1'b0;
    end else if (wr_ok && Writ_Enable) begin
      valid_d[WR_Addr] = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rest && wr_ok && Writ_Enable && !Inval_Enable) begin
      mem_q[WR_Addr] <= Data_IN;
    end
  end

  always_comb begin
    bank_base  = AW'(bank_q) * AW'(E);
    bank_pop   = '0;
    bank_any   = 1'b0;
    bank_first = '0;
    idx        = '0;
    for (int j = 0; j < E; j++) begin
      idx = bank_base + AW'(j);
      if (valid_q[idx] && (mem_q[idx] == key_q)) begin
        bank_pop = bank_pop + CW'(1);
        if (!bank_any) begin
          bank_first = idx;
        end
        bank_any = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    bank_d      = bank_q;
    key_d       = key_q;
    acc_cnt_d   = acc_cnt_q;
    acc_hit_d   = acc_hit_q;
    acc_addr_d  = acc_addr_q;
    res_match_d = res_match_q;
    res_multi_d = res_multi_q;
    res_addr_d  = res_addr_q;
    res_cnt_d   = res_cnt_q;
    case (state_q)
      SEARCH: begin
        acc_cnt_d = acc_cnt_q + bank_pop;
        // The first bank with a hit owns the address; later banks never override it.
        if (!acc_hit_q && bank_any) begin
          acc_hit_d  = 1'b1;
          acc_addr_d = bank_first;
        end
        bank_d = bank_q + 1'b1;
        if (bank_q == BW'(Banks - 1)) begin
          state_d     = DONE;
          res_match_d = acc_hit_d;
          res_multi_d = (acc_cnt_d >= CW'(2));
          res_addr_d  = acc_addr_d;
          res_cnt_d   = acc_cnt_d;
        end
      end
      default: begin
        if (state_q == DONE) begin
          state_d = IDLE;
        end
        if (Cmp_Start) begin
          state_d    = SEARCH;
          key_d      = CMP_Din;
          bank_d     = '0;
          acc_cnt_d  = '0;
          acc_hit_d  = 1'b0;
          acc_addr_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rest) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      bank_q      <= '0;
      key_q       <= '0;
      acc_cnt_q   <= '0;
      acc_hit_q   <= 1'b0;
      acc_addr_q  <= '0;
      res_match_q <= 1'b0;
      res_multi_q <= 1'b0;
      res_addr_q  <= '0;
      res_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      bank_q      <= bank_d;
      key_q       <= key_d;
      acc_cnt_q   <= acc_cnt_d;
      acc_hit_q   <= acc_hit_d;
      acc_addr_q  <= acc_addr_d;
      res_match_q <= res_match_d;
      res_multi_q <= res_multi_d;
      res_addr_q  <= res_addr_d;
      res_cnt_q   <= res_cnt_d;
    end
  end

  assign Busy        = (state_q == SEARCH);
  assign Done        = (state_q == DONE);
  assign Match       = res_match_q;
  assign Multi_Match = res_multi_q;
  assign Match_Addr  = res_addr_q;
  assign Match_Count = res_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_cam_banked_search.sv
// tb_cam_banked_search: randomized and directed checks of cam_banked_search
// against an array-based reference of the CAM contents.
`default_nettype none

module tb_cam_banked_search;

  logic        clk;
  logic        rst_n;

  // Default-parameter instance (48 x 48, 4 banks)
  logic        a_we, a_inv, a_start;
  logic [5:0]  a_addr;
  logic [47:0] a_din, a_key;
  logic        a_busy, a_done, a_match, a_multi;
  logic [5:0]  a_maddr, a_mcnt;

  // Small instance (8 x 16, 2 banks)
  logic        b_we, b_inv, b_start;
  logic [3:0]  b_addr;
  logic [7:0]  b_din, b_key;
  logic        b_busy, b_done, b_match, b_multi;
  logic [3:0]  b_maddr;
  logic [4:0]  b_mcnt;

  int n_checks = 0;
  int n_pass   = 0;

  bit [47:0] m_mem [48];
  bit        m_val [48];

  cam_banked_search u_dut_a (
    .Clk(clk), .Rest(rst_n), .Writ_Enable(a_we), .Inval_Enable(a_inv),
    .WR_Addr(a_addr), .Data_IN(a_din), .Cmp_Start(a_start), .CMP_Din(a_key),
    .Busy(a_busy), .Done(a_done), .Match(a_match), .Multi_Match(a_multi),
    .Match_Addr(a_maddr), .Match_Count(a_mcnt)
  );

  cam_banked_search #(.CAM_Width(8), .CAM_Depth(16), .Banks(2)) u_dut_b (
    .Clk(clk), .Rest(rst_n), .Writ_Enable(b_we), .Inval_Enable(b_inv),
    .WR_Addr(b_addr), .Data_IN(b_din), .Cmp_Start(b_start), .CMP_Din(b_key),
    .Busy(b_busy), .Done(b_done), .Match(b_match), .Multi_Match(b_multi),
    .Match_Addr(b_maddr), .Match_Count(b_mcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit [47:0] pkey(input int v);
    return {8'hA5, 40'(v)};
  endfunction

  task automatic model_write(input int addr, input bit [47:0] d, input bit we, input bit inv);
    if (addr < 48) begin
      if (inv) m_val[addr] = 1'b0;
      else if (we) begin
        m_mem[addr] = d;
        m_val[addr] = 1'b1;
      end
    end
  endtask

  task automatic a_write(input int addr, input bit [47:0] d, input bit we, input bit inv);
    a_addr = addr[5:0]; a_din = d; a_we = we; a_inv = inv;
    tick();
    a_we = 1'b0; a_inv = 1'b0;
    model_write(addr, d, we, inv);
  endtask

  task automatic check_result(input string tag, input bit [47:0] key);
    int cnt, first;
    cnt = 0; first = 0;
    for (int i = 0; i < 48; i++) begin
      if (m_val[i] && m_mem[i] == key) begin
        if (cnt == 0) first = i;
        cnt++;
      end
    end
    check({tag, "_match"}, a_match, (cnt > 0));
    check({tag, "_multi"}, a_multi, (cnt >= 2));
    check({tag, "_addr"},  a_maddr, first);
    check({tag, "_count"}, a_mcnt, cnt);
  endtask

  // Searches key; optionally writes in the start cycle (model sees it) or in
  // the first busy cycle (dropped by the DUT, so the model is untouched).
  task automatic a_search(input string tag, input bit [47:0] key,
                          input bit co_write, input int waddr, input bit [47:0] wdata,
                          input bit busy_write);
    int cyc, busy_n;
    a_start = 1'b1; a_key = key;
    if (co_write) begin
      a_addr = waddr[5:0]; a_din = wdata; a_we = 1'b1;
    end
    tick();
    a_start = 1'b0; a_we = 1'b0;
    if (co_write) model_write(waddr, wdata, 1'b1, 1'b0);
    cyc = 1; busy_n = 0;
    while (!a_done && cyc < 30) begin
      if (a_busy) busy_n++;
      if (busy_write && cyc == 1) begin
        a_addr = 6'd7; a_din = 48'h7777; a_we = 1'b1;
      end
      tick();
      a_we = 1'b0;
      cyc++;
    end
    check({tag, "_lat"}, cyc, 5);
    check({tag, "_busycyc"}, busy_n, 4);
    check_result(tag, key);
    tick();
    check({tag, "_donepulse"}, a_done, 0);
  endtask

  initial begin
    int cyc, seen;
    rst_n = 1'b0;
    a_we = 0; a_inv = 0; a_start = 0; a_addr = 0; a_din = 0; a_key = 0;
    b_we = 0; b_inv = 0; b_start = 0; b_addr = 0; b_din = 0; b_key = 0;
    for (int i = 0; i < 48; i++) begin m_val[i] = 1'b0; m_mem[i] = '0; end
    repeat (3) tick();
    rst_n = 1'b1;
    check("rst_busy", a_busy, 0);
    check("rst_done", a_done, 0);
    check("rst_match", a_match, 0);
    check("rst_count", a_mcnt, 0);
    check("rst_addr", a_maddr, 0);

    a_search("empty", 48'h0, 0, 0, 0, 0);

    a_write(5, 48'hABCD, 1, 0);
    a_write(40, 48'hABCD, 1, 0);
    a_search("two_hits", 48'hABCD, 0, 0, 0, 0);
    a_write(5, 48'h0, 0, 1);
    a_search("after_inval", 48'hABCD, 0, 0, 0, 0);

    a_search("busy_wr", 48'h1234, 0, 0, 0, 1);
    a_search("busy_wr_look", 48'h7777, 0, 0, 0, 0);

    a_write(3, 48'h3333, 1, 0);
    a_write(3, 48'h4444, 1, 1);
    a_search("wi_new", 48'h4444, 0, 0, 0, 0);
    a_search("wi_old", 48'h3333, 0, 0, 0, 0);

    a_write(50, 48'hABCD, 1, 0);
    a_search("oob", 48'hABCD, 0, 0, 0, 0);

    a_search("co_write", 48'hBEEF, 1, 10, 48'hBEEF, 0);
    a_write(10, 48'hCAFE, 1, 0);
    a_search("overwrite", 48'hCAFE, 0, 0, 0, 0);

    // Reset in the second search cycle aborts without a Done pulse.
    a_write(20, 48'h9999, 1, 0);
    a_search("pre_rst", 48'h9999, 0, 0, 0, 0);
    a_start = 1'b1; a_key = 48'h9999;
    tick();
    a_start = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 48; i++) m_val[i] = 1'b0;
    check("abort_busy", a_busy, 0);
    check("abort_done", a_done, 0);
    check("abort_match", a_match, 0);
    check("abort_multi", a_multi, 0);
    check("abort_addr", a_maddr, 0);
    check("abort_count", a_mcnt, 0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (a_done) seen++;
      tick();
    end
    check("abort_nodone", seen, 0);
    a_search("post_rst", 48'h9999, 0, 0, 0, 0);

    // Back-to-back with Cmp_Start held through DONE.
    a_write(2, 48'hABCD, 1, 0);
    a_write(45, 48'hABCD, 1, 0);
    a_start = 1'b1; a_key = 48'hABCD;
    tick();
    cyc = 1;
    while (!a_done && cyc < 30) begin tick(); cyc++; end
    check("b2b_lat1", cyc, 5);
    check_result("b2b_first", 48'hABCD);
    tick();
    a_start = 1'b0;
    check("b2b_busy2", a_busy, 1);
    check("b2b_done2", a_done, 0);
    cyc = 1;
    while (!a_done && cyc < 30) begin tick(); cyc++; end
    check("b2b_lat2", cyc, 5);
    check_result("b2b_second", 48'hABCD);
    tick();

    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 9) < 6) begin
        a_write($urandom_range(0, 51), pkey($urandom_range(0, 4)),
                1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0));
      end else begin
        a_search("rnd", pkey($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 47), pkey($urandom_range(0, 4)), 0);
      end
    end

    // Small configuration: latency Banks+1 = 3, back-to-back.
    b_addr = 4'd3;  b_din = 8'h5A; b_we = 1'b1; tick();
    b_addr = 4'd12; tick();
    b_addr = 4'd6;  b_din = 8'h11; tick();
    b_we = 1'b0;
    b_start = 1'b1; b_key = 8'h5A;
    tick();
    check("b_busy1", b_busy, 1);
    cyc = 1;
    while (!b_done && cyc < 30) begin tick(); cyc++; end
    check("b_lat1", cyc, 3);
    check("b_match", b_match, 1);
    check("b_multi", b_multi, 1);
    check("b_addr", b_maddr, 3);
    check("b_count", b_mcnt, 2);
    tick();
    b_key = 8'h11;
    b_start = 1'b0;
    check("b_b2b_busy", b_busy, 1);
    cyc = 1;
    while (!b_done && cyc < 30) begin tick(); cyc++; end
    check("b_lat2", cyc, 3);
    check("b2_match", b_match, 1);
    check("b2_multi", b_multi, 1);
    check("b2_count", b_mcnt, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cam_banked_search.md
CAM_BANKED_SEARCH -- requirements
Module: cam_banked_search

Interface
REQ-001 Parameter CAM_Width, default 48, bit width of each stored word and of the compare key.
REQ-002 Parameter CAM_Depth, default 48, number of entries; SHALL be ≥ 2.
REQ-003 Parameter Banks, default 4, number of search banks; CAM_Depth SHALL be an integer multiple of Banks (elaboration error otherwise).
REQ-004 Derived widths: AW = clog2(CAM_Depth); CW = clog2(CAM_Depth+1); E = CAM_Depth/Banks entries per bank.
REQ-005 Clk  in  1  sole clock; all state changes on its rising edge.
REQ-006 Rest  in  1  reset; synchronous, active-low.
REQ-007 Writ_Enable  in  1  write Data_IN into entry WR_Addr and mark it valid.
REQ-008 Inval_Enable  in  1  clear the valid bit of entry WR_Addr.
REQ-009 WR_Addr  in  AW  target entry for write or invalidate.
REQ-010 Data_IN  in  CAM_Width  write data.
REQ-011 Cmp_Start  in  1  request a search for CMP_Din.
REQ-012 CMP_Din  in  CAM_Width  search key, sampled with an accepted Cmp_Start.
REQ-013 Busy  out  1  search in progress; Cmp_Start, Writ_Enable and Inval_Enable are ignored while high.
REQ-014 Done  out  1  single-cycle pulse; result outputs are valid and remain held until the next accepted Cmp_Start.
REQ-015 Match  out  1  at least one valid entry equals the key.
REQ-016 Multi_Match  out  1  two or more valid entries equal the key.
REQ-017 Match_Addr  out  AW  lowest-index matching entry; 0 when Match=0.
REQ-018 Match_Count  out  CW  number of matching valid entries.

Function
REQ-019 Storage: CAM_Depth words of CAM_Width bits plus one valid bit per entry; an invalid entry SHALL never match.
REQ-020 FSM states: IDLE, SEARCH, DONE.
REQ-021 IDLE -> SEARCH when Cmp_Start=1. On that edge the block latches CMP_Din, clears the bank index to 0, clears the partial-result registers and sets Busy=1.
REQ-022 SEARCH: each cycle compare the latched key against the E entries of the current bank and increment the bank index. After bank Banks-1, go to DONE.
REQ-023 DONE: Busy=0, Done=1 for exactly one cycle, then go to IDLE. Cmp_Start in DONE SHALL be accepted exactly as in IDLE.
REQ-024 Latency: Cmp_Start sampled at edge t gives Busy=1 during cycles t+1..t+Banks and Done=1 during cycle t+Banks+1.
REQ-025 Priority: Match_Addr is the lowest matching index over the whole array. Banks are scanned in ascending order, and a later bank SHALL NOT overwrite an earlier hit.
REQ-026 Match_Count accumulates per-bank popcounts and saturates cannot occur (maximum is CAM_Depth). Multi_Match = (Match_Count ≥ 2).
REQ-027 Result outputs (Match, Multi_Match, Match_Addr, Match_Count) update only at the transition into DONE and are otherwise held.
REQ-028 Writes and invalidates are accepted only when Busy=0 and commit on the sampling edge.
REQ-029 Writ_Enable together with Cmp_Start in the same cycle: the write commits on that edge and the search SHALL observe the new data.
REQ-030 Writ_Enable and Inval_Enable together on the same address: the entry is invalidated and the data word is unchanged.
REQ-031 WR_Addr ≥ CAM_Depth: the write or invalidate is dropped with no state change.
REQ-032 Writing to an already-valid entry overwrites the data; the entry stays valid.

Reset
REQ-033 Rest=0 at a rising edge SHALL force IDLE and clear all valid bits. It also clears the bank index, Busy, Done, Match, Multi_Match, Match_Addr and Match_Count to 0. Stored data is don't-care.
REQ-034 Reset during SEARCH aborts the search; no Done pulse follows.
REQ-035 While Rest=0, all inputs are ignored.

Verification
REQ-036 Empty CAM after reset, search 0x0 -> Done at t+5 (Banks=4); Match=0, Match_Count=0, Match_Addr=0.
REQ-037 Write 0xABCD at entries 5 and 40, search 0xABCD -> Match=1, Multi_Match=1, Match_Count=2, Match_Addr=5.
REQ-038 Invalidate entry 5, search 0xABCD -> Match_Count=1, Match_Addr=40, Multi_Match=0.
REQ-039 Write to entry 7 issued while Busy=1, then search its data -> no match. Writ_Enable and Inval_Enable on entry 3 together -> entry 3 never matches.
REQ-040 Rest=0 during SEARCH cycle 2 -> next cycle Busy=0; no Done; all outputs 0; a later search of previously written data -> Match=0.
REQ-041 Back-to-back: Cmp_Start held through DONE -> second search's Busy rises in the cycle after Done. Repeat with CAM_Width=8, CAM_Depth=16, Banks=2 and check latency t+3.
